// File: rtl/mac_pipe.sv
// rtl/mac_pipe.sv - pipelined multiply-accumulate with sticky overflow flag
module mac_pipe #(
  parameter int WIDTH     = 32,
  parameter int LATENCY   = 2,
  parameter int SIGNED    = 1,
  parameter int ACC_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 t,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 acc_en,
  output logic [ACC_WIDTH-1:0] out,
  output logic                 tout,
  output logic                 ovf
);

  localparam bit IS_SIGNED = (SIGNED != 0);

  logic [2*WIDTH-1:0]   prod_c;
  logic [2*WIDTH-1:0]   fin_prod;
  logic                 fin_v;
  logic                 fin_acc;
  logic [ACC_WIDTH-1:0] fin_ext;
  logic [ACC_WIDTH-1:0] sum_c;
  logic                 carry_c;
  logic                 ovf_c;

  generate
    if (IS_SIGNED) begin : g_signed
      logic signed [2*WIDTH-1:0] a_ext;
      logic signed [2*WIDTH-1:0] b_ext;
      assign a_ext   = (2*WIDTH)'($signed(a));
      assign b_ext   = (2*WIDTH)'($signed(b));
      assign prod_c  = a_ext * b_ext;
      assign fin_ext = ACC_WIDTH'($signed(fin_prod));
    end else begin : g_unsigned
      assign prod_c  = (2*WIDTH)'(a) * (2*WIDTH)'(b);
      assign fin_ext = ACC_WIDTH'(fin_prod);
    end
  endgenerate

  // The last pipeline stage is the accumulator itself, so LATENCY-1 product stages precede it.
  generate
    if (LATENCY == 1) begin : g_direct
      assign fin_v    = t;
      assign fin_acc  = acc_en;
      assign fin_prod = prod_c;
    end else begin : g_stages
      logic [LATENCY-2:0] v_q;
      logic [LATENCY-2:0] acc_q;
      logic [2*WIDTH-1:0] prod_q [LATENCY-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= '0;
        end else begin
          v_q[0] <= t;
          for (int i = 1; i < LATENCY - 1; i++) begin
            v_q[i] <= v_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        acc_q[0]  <= acc_en;
        prod_q[0] <= prod_c;
        for (int i = 1; i < LATENCY - 1; i++) begin
          acc_q[i]  <= acc_q[i-1];
          prod_q[i] <= prod_q[i-1];
        end
      end

      assign fin_v    = v_q[LATENCY-2];
      assign fin_acc  = acc_q[LATENCY-2];
      assign fin_prod = prod_q[LATENCY-2];
    end
  endgenerate

  // Summing against the registered out gives back-to-back accumulates the fresh value.
  assign {carry_c, sum_c} = {1'b0, out} + {1'b0, fin_ext};
  assign ovf_c = IS_SIGNED ? ((out[ACC_WIDTH-1] == fin_ext[ACC_WIDTH-1]) &&
                              (sum_c[ACC_WIDTH-1] != out[ACC_WIDTH-1]))
                           : carry_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      out  <= '0;
      tout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      tout <= fin_v;
      if (fin_v) begin
        if (fin_acc) begin
          out <= sum_c;
          ovf <= ovf | ovf_c;
        end else begin
          out <= fin_ext;
          ovf <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe.sv
// tb/tb_mac_pipe.sv - scoreboard bench for mac_pipe (signed L=2 and unsigned L=4 instances)
module tb_mac_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        t0, ae0, t1, ae1;
  logic [31:0] a0, b0, a1, b1;
  logic [63:0] out0, out1;
  logic        tout0, ovf0, tout1, ovf1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [63:0] out;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_pipe #(.WIDTH(32), .LATENCY(2), .SIGNED(1), .ACC_WIDTH(64)) dut0 (
    .clk(clk), .rst(rst), .t(t0), .a(a0), .b(b0), .acc_en(ae0),
    .out(out0), .tout(tout0), .ovf(ovf0)
  );

  mac_pipe #(.WIDTH(32), .LATENCY(4), .SIGNED(0), .ACC_WIDTH(64)) dut1 (
    .clk(clk), .rst(rst), .t(t1), .a(a1), .b(b1), .acc_en(ae1),
    .out(out1), .tout(tout1), .ovf(ovf1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic iss0(input logic [31:0] a, input logic [31:0] b, input logic ae,
                      input logic [63:0] eo, input logic eov);
    exp_t e;
    @(posedge clk); #1;
    t0 = 1'b1; a0 = a; b0 = b; ae0 = ae; t1 = 1'b0;
    e.out = eo; e.ovf = eov; e.cyc = cyc + 2;
    q0.push_back(e);
  endtask

  task automatic iss1(input logic [31:0] a, input logic [31:0] b, input logic ae,
                      input logic [63:0] eo, input logic eov);
    exp_t e;
    @(posedge clk); #1;
    t1 = 1'b1; a1 = a; b1 = b; ae1 = ae; t0 = 1'b0;
    e.out = eo; e.ovf = eov; e.cyc = cyc + 4;
    q1.push_back(e);
  endtask

  task automatic bubble0();
    @(posedge clk); #1;
    t0 = 1'b0; a0 = $urandom; b0 = $urandom; ae0 = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      t0 = 1'b0; t1 = 1'b0;
    end
  endtask

  // Monitor: every tout must match the oldest outstanding expectation, in value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (tout0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL d0_unexpected_tout actual=1 required=0 cyc=%0d", cyc);
      end else begin
        e = q0.pop_front();
        chk("d0_out", out0, e.out);
        chk("d0_ovf", {63'd0, ovf0}, {63'd0, e.ovf});
        chk("d0_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (tout1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL d1_unexpected_tout actual=1 required=0 cyc=%0d", cyc);
      end else begin
        e = q1.pop_front();
        chk("d1_out", out1, e.out);
        chk("d1_ovf", {63'd0, ovf1}, {63'd0, e.ovf});
        chk("d1_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    t0 = 1'b0; a0 = '0; b0 = '0; ae0 = 1'b0;
    t1 = 1'b0; a1 = '0; b1 = '0; ae1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out0", out0, 64'd0);
    chk("rst_tout0", {63'd0, tout0}, 64'd0);
    chk("rst_ovf0", {63'd0, ovf0}, 64'd0);
    chk("rst_out1", out1, 64'd0);
    chk("rst_tout1", {63'd0, tout1}, 64'd0);
    chk("rst_ovf1", {63'd0, ovf1}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // signed load, then hold
    iss0(32'd3, -32'sd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0);
    idle(3);
    @(negedge clk);
    chk("hold_tout0", {63'd0, tout0}, 64'd0);
    chk("hold_out0", out0, 64'hFFFF_FFFF_FFFF_FFF4);

    // back-to-back accumulate with a bubble
    iss0(32'd1, 32'd1, 1'b0, 64'd1, 1'b0);
    iss0(32'd2, 32'd2, 1'b1, 64'd5, 1'b0);
    bubble0();
    iss0(32'd3, 32'd3, 1'b1, 64'd14, 1'b0);
    idle(4);
    @(negedge clk);
    chk("bubble_out0", out0, 64'd14);

    // mixed signs crossing zero
    iss0(-32'sd5, 32'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFDD, 1'b0);
    iss0(32'd6, 32'd6, 1'b1, 64'd1, 1'b0);

    // signed overflow, sticky hold, cleared by load
    iss0(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 1'b0);
    iss0(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h8000_0000_0000_0000, 1'b1);
    iss0(32'd0, 32'd0, 1'b1, 64'h8000_0000_0000_0000, 1'b1);
    iss0(32'd1, 32'd1, 1'b0, 64'd1, 1'b0);
    idle(4);

    // unsigned instance, LATENCY=4, carry-out overflow
    iss1(32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE, 1'b0);
    iss1(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
    iss1(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFC_0000_0002, 1'b1);
    iss1(32'd1, 32'd1, 1'b1, 64'hFFFF_FFFC_0000_0003, 1'b1);
    iss1(32'd3, 32'd3, 1'b0, 64'd9, 1'b0);
    idle(8);

    // reset while issues are in flight; t asserted during reset is ignored
    @(posedge clk); #1;
    t0 = 1'b1; a0 = 32'd5; b0 = 32'd5; ae0 = 1'b0;
    t1 = 1'b1; a1 = 32'd5; b1 = 32'd5; ae1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; t0 = 1'b1; t1 = 1'b1; ae0 = 1'b0; ae1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; t0 = 1'b0; t1 = 1'b0;
    idle(8);
    @(negedge clk);
    chk("midrst_out0", out0, 64'd0);
    chk("midrst_ovf0", {63'd0, ovf0}, 64'd0);
    chk("midrst_out1", out1, 64'd0);
    chk("midrst_ovf1", {63'd0, ovf1}, 64'd0);

    // accumulate starting from the reset value
    iss0(32'd2, 32'd3, 1'b1, 64'd6, 1'b0);
    iss1(32'd4, 32'd5, 1'b1, 64'd20, 1'b0);
    idle(8);
    @(negedge clk);
    chk("d0_pending", 64'(q0.size()), 64'd0);
    chk("d1_pending", 64'(q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
